dispatch_buffered: RTL and testbench
====================================

// Module: dispatch_buffered
// PURPOSE
//   Parametrised successor to the combinational dispatch stage. Holds one decoded bundle of
//   up to WIDTH micro-ops and routes them to NUM_IQ issue queues under per-queue free-slot
//   credits, dispatching strictly in program order and stalling the front-end when a queue
//   is full. Sits between rename and the issue queues; adds flush and a stall-cycle counter.
// PARAMETERS
//   WIDTH   4  micro-ops per bundle and output slots per queue (power of 2, >= 2)
//   NUM_IQ  3  issue-queue channels; iq_code value q selects channel q (IQ_INT=0, IQ_MEM=1, IQ_AP=2)
//   CW      $clog2(WIDTH+1)  derived credit/count width
// PORTS
//   clock             in   1               system clock
//   reset             in   1               synchronous, active-high
//   flush             in   1               discard held bundle (branch mispredict / exception)
//   uop_in            in   WIDTH x uop     micro_op_t bundle; per-slot .valid, .iq_code
//   uop_in_ready      out  1               bundle accepted at posedge when high
//   iq_free           in   NUM_IQ x CW     free entries in each queue this cycle (0..WIDTH)
//   uop_out           out  NUM_IQ x WIDTH x uop  per-queue compacted micro-ops; unused slots all-zero
//   dispatched_count  out  CW              micro-ops sent this cycle
//   stall_cycles      out  32              saturating count of blocked cycles
// BEHAVIOUR
//   State: bundle register buf[WIDTH] (micro_op_t) + pending[WIDTH] bits; stall_cycles reg.
//   Reset (sync): pending=0, buf=0, stall_cycles=0. While reset high: uop_in_ready=0, all
//     uop_out=0, dispatched_count=0. First cycle after reset: uop_in_ready=1.
//   Capture: on posedge with uop_in_ready=1: buf<=uop_in; pending[i]<=uop_in[i].valid &&
//     iq_code<NUM_IQ (out-of-range codes dropped). Slots with valid=0 are never pending.
//   Selection (combinational from buf/pending/iq_free): walk slots 0..WIDTH-1; a pending slot
//     with code q dispatches iff every earlier pending slot dispatched and count of already
//     selected slots for q < iq_free[q]. First failing pending slot stops all later slots
//     (in-order; no bypass). Non-pending slots are skipped, do not stop the walk.
//   Output: k-th selected uop for queue q appears on uop_out[q][k], k=0.., in slot order;
//     remaining uop_out[q][*]=0. dispatched_count = total selected. Latency: uop captured at
//     edge N is visible on uop_out in cycle N (after edge), earliest.
//   Update: pending[i] cleared at posedge for every dispatched slot.
//   uop_in_ready = !reset && !flush && (all pending slots dispatched this cycle). Empty buffer
//     => ready=1; last pending slots leaving and new bundle capture occur at the same edge.
//   Flush: combinationally forces uop_out=0, dispatched_count=0, uop_in_ready=0; at posedge
//     pending<=0. Flush overrides dispatch; reset overrides flush.
//   stall_cycles: +1 at posedge when any pending bit set, dispatched_count==0, no flush;
//     saturates at 32'hFFFF_FFFF. Not cleared by flush.
//   Boundaries: iq_free>WIDTH treated as WIDTH; all iq_free=0 with pending => full stall,
//     outputs zero; all-invalid input bundle accepted, leaves buffer empty.
// TESTING
//   1 reset 2 cycles -> ready=0, uop_out all 0, stall_cycles=0; cycle after release ready=1.
//   2 bundle {INT,MEM,INT,AP}, free={4,4,4} -> next cycle INT[0]=s0, INT[1]=s2, MEM[0]=s1,
//     AP[0]=s3, dispatched_count=4, ready=1; following cycle outputs 0 if no new input.
//   3 bundle {INT,INT,MEM,INT}, free INT=1 -> s0 only, count=1, ready=0; next cycle INT=4
//     -> INT[0]=s1, INT[1]=s3, MEM[0]=s2, count=3, ready=1, new bundle captured same edge.
//   4 bundle {MEM,INT,..}, MEM free=0 for 5 cycles -> no outputs (INT not bypassed),
//     stall_cycles +5; MEM free=1 -> s0 and s1 dispatch, stall stops.
//   5 after partial dispatch (2 pending) assert flush 1 cycle -> outputs 0 that cycle, buffer
//     empty next cycle, flushed uops never appear, ready=1; flush+reset together -> reset wins.
//   6 valid={1,0,1,0} codes {AP,-,AP,-}, AP free=1 -> s0 dispatched, s2 held; iq_code=3
//     slot -> dropped, never output; stall_cycles preloaded near max -> saturates, no wrap.

Source files
------------

// File: rtl/dispatch_buffered.sv
// rtl/dispatch_buffered.sv - buffered in-order dispatch of one micro-op bundle to credit-limited issue queues
//
// Purpose: holds one rename bundle and routes its micro-ops, strictly in program
//   order, to NUM_IQ issue queues subject to each queue's free-slot credit. The
//   front end is stalled until every held micro-op has left. Supports flush and
//   keeps a saturating count of blocked cycles.
// Ports:
//   clk_i               system clock
//   reset_i             synchronous, active-high
//   flush_i             discard the held bundle
//   uop_in_i            WIDTH-slot bundle from rename
//   uop_in_ready_o      bundle accepted at the next posedge when high
//   iq_free_i           free entries per queue this cycle (values above WIDTH clamp)
//   uop_out_o           per-queue compacted micro-ops, unused slots zero
//   dispatched_count_o  micro-ops sent this cycle
//   stall_cycles_o      saturating count of cycles with work held but nothing sent

package dispatch_pkg;
  localparam logic [1:0] IQ_INT = 2'd0;
  localparam logic [1:0] IQ_MEM = 2'd1;
  localparam logic [1:0] IQ_AP  = 2'd2;

  typedef struct packed {
    logic        valid;
    logic [1:0]  iq_code;
    logic [15:0] payload;
  } micro_op_t;
endpackage

module dispatch_buffered
  import dispatch_pkg::*;
#(
  parameter int          WIDTH      = 4,
  parameter int          NUM_IQ     = 3,
  parameter int          CW         = $clog2(WIDTH + 1),
  parameter logic [31:0] STALL_INIT = 32'd0
) (
  input  logic                                 clk_i,
  input  logic                                 reset_i,
  input  logic                                 flush_i,
  input  micro_op_t [WIDTH-1:0]                uop_in_i,
  output logic                                 uop_in_ready_o,
  input  logic [NUM_IQ-1:0][CW-1:0]            iq_free_i,
  output micro_op_t [NUM_IQ-1:0][WIDTH-1:0]    uop_out_o,
  output logic [CW-1:0]                        dispatched_count_o,
  output logic [31:0]                          stall_cycles_o
);
  localparam int IW = $clog2(WIDTH);

  micro_op_t [WIDTH-1:0]             bundle_q, bundle_d;
  logic [WIDTH-1:0]                  pend_q, pend_d;
  logic [31:0]                       stall_q, stall_d;

  logic [WIDTH-1:0]                  sel;
  micro_op_t [NUM_IQ-1:0][WIDTH-1:0] route;
  logic [CW-1:0]                     total;
  logic                              all_done;
  logic                              ready;

  // In-order walk: the first pending slot that cannot get a credit blocks every
  // later slot, even ones bound for a queue that still has room.
  always_comb begin : select_walk
    logic                      blocked;
    logic [NUM_IQ-1:0][CW-1:0] cnt;
    logic [CW-1:0]             lim;
    blocked = 1'b0;
    cnt     = '0;
    lim     = '0;
    sel     = '0;
    route   = '0;
    total   = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (pend_q[i] && !blocked) begin
        for (int j = 0; j < NUM_IQ; j++) begin
          if (32'(bundle_q[i].iq_code) == j) begin
            lim = (iq_free_i[j] > CW'(WIDTH)) ? CW'(WIDTH) : iq_free_i[j];
            if (cnt[j] < lim) begin
              route[j][cnt[j][IW-1:0]] = bundle_q[i];
              cnt[j] = cnt[j] + CW'(1);
              sel[i] = 1'b1;
              total  = total + CW'(1);
            end else begin
              blocked = 1'b1;
            end
          end
        end
      end
    end
  end

  assign all_done = ((pend_q & ~sel) == '0);
  assign ready    = !reset_i && !flush_i && all_done;

  assign uop_in_ready_o     = ready;
  assign uop_out_o          = (reset_i || flush_i) ? '0 : route;
  assign dispatched_count_o = (reset_i || flush_i) ? '0 : total;
  assign stall_cycles_o     = stall_q;

  always_comb begin
    bundle_d = bundle_q;
    pend_d   = pend_q & ~sel;
    stall_d  = stall_q;
    if (flush_i) begin
      pend_d = '0;
    end else if (ready) begin
      // Invalid slots and out-of-range queue codes never become pending.
      bundle_d = uop_in_i;
      for (int i = 0; i < WIDTH; i++) begin
        pend_d[i] = uop_in_i[i].valid && (32'(uop_in_i[i].iq_code) < NUM_IQ);
      end
    end
    if (!flush_i && (|pend_q) && (total == '0) && (stall_q != 32'hFFFF_FFFF)) begin
      stall_d = stall_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      bundle_q <= '0;
      pend_q   <= '0;
      stall_q  <= STALL_INIT;
    end else begin
      bundle_q <= bundle_d;
      pend_q   <= pend_d;
      stall_q  <= stall_d;
    end
  end
endmodule

// File: tb/tb_dispatch_buffered.sv
// tb/tb_dispatch_buffered.sv - scoreboard bench for dispatch_buffered against a queue-based model
module tb_dispatch_buffered;
  import dispatch_pkg::*;

  localparam int WIDTH  = 4;
  localparam int NUM_IQ = 3;
  localparam int CW     = 3;

  typedef micro_op_t [WIDTH-1:0] bundle_t;
  typedef micro_op_t [NUM_IQ-1:0][WIDTH-1:0] out_t;
  typedef logic [NUM_IQ-1:0][CW-1:0] free_t;
  typedef struct {
    out_t          out;
    logic [CW-1:0] cnt;
    logic          rdy;
    logic [31:0]   stall;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset = 1'b1;
  logic          flush = 1'b0;
  bundle_t       uop_in = '0;
  free_t         iq_free = '0;
  logic          ready;
  out_t          uop_out;
  logic [CW-1:0] dcount;
  logic [31:0]   stall;

  logic          r2 = 1'b1;
  logic          f2 = 1'b0;
  bundle_t       b2 = '0;
  free_t         fr2 = '0;
  logic          ready2;
  out_t          uop_out2;
  logic [CW-1:0] dcount2;
  logic [31:0]   stall2;

  dispatch_buffered #(.WIDTH(WIDTH), .NUM_IQ(NUM_IQ)) dut (
    .clk_i(clk), .reset_i(reset), .flush_i(flush), .uop_in_i(uop_in),
    .uop_in_ready_o(ready), .iq_free_i(iq_free), .uop_out_o(uop_out),
    .dispatched_count_o(dcount), .stall_cycles_o(stall)
  );

  dispatch_buffered #(.WIDTH(WIDTH), .NUM_IQ(NUM_IQ), .STALL_INIT(32'hFFFF_FFFC)) dut_sat (
    .clk_i(clk), .reset_i(r2), .flush_i(f2), .uop_in_i(b2),
    .uop_in_ready_o(ready2), .iq_free_i(fr2), .uop_out_o(uop_out2),
    .dispatched_count_o(dcount2), .stall_cycles_o(stall2)
  );

  int          checks = 0;
  int          errors = 0;
  exp_t        sb[$];
  micro_op_t   mq[$];
  logic [31:0] m_stall = 32'd0;
  int          pay = 0;
  bit          done2 = 1'b0;

  task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
    end
  endtask

  function automatic micro_op_t mk(input logic v, input logic [1:0] c);
    micro_op_t u;
    pay++;
    u.valid   = v;
    u.iq_code = c;
    u.payload = 16'(pay);
    return u;
  endfunction

  function automatic bundle_t bnd(input logic [3:0] v, input logic [1:0] c0, input logic [1:0] c1,
                                  input logic [1:0] c2, input logic [1:0] c3);
    bundle_t b;
    b[0] = mk(v[0], c0);
    b[1] = mk(v[1], c1);
    b[2] = mk(v[2], c2);
    b[3] = mk(v[3], c3);
    return b;
  endfunction

  function automatic free_t fv(input int a, input int m, input int p);
    free_t f;
    f[0] = CW'(a);
    f[1] = CW'(m);
    f[2] = CW'(p);
    return f;
  endfunction

  // Model: held micro-ops are a program-ordered list; each cycle take from the
  // head while the head's queue still has credit, stop at the first that does not.
  task automatic step(input logic rst, input logic fl, input bundle_t b, input free_t fr, input bit chk);
    exp_t e;
    out_t o;
    int   used[NUM_IQ];
    int   n, q, lim;
    @(posedge clk);
    #1;
    reset   = rst;
    flush   = fl;
    uop_in  = b;
    iq_free = fr;
    e.out   = '0;
    e.cnt   = '0;
    e.rdy   = 1'b0;
    e.stall = m_stall;
    if (rst) begin
      mq.delete();
      m_stall = 32'd0;
    end else begin
      o = '0;
      n = 0;
      foreach (used[j]) used[j] = 0;
      while (n < mq.size()) begin
        q   = int'(mq[n].iq_code);
        lim = (int'(fr[q]) > WIDTH) ? WIDTH : int'(fr[q]);
        if (used[q] >= lim) break;
        o[q][used[q]] = mq[n];
        used[q]++;
        n++;
      end
      if (fl) begin
        mq.delete();
      end else begin
        e.out = o;
        e.cnt = CW'(n);
        e.rdy = (n == mq.size());
        if (mq.size() > 0 && n == 0 && m_stall != 32'hFFFF_FFFF) m_stall++;
        repeat (n) void'(mq.pop_front());
        if (e.rdy) begin
          for (int i = 0; i < WIDTH; i++)
            if (b[i].valid && int'(b[i].iq_code) < NUM_IQ) mq.push_back(b[i]);
        end
      end
    end
    if (chk) sb.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("uop_out", 256'(uop_out), 256'(e.out));
        check("dispatched_count", 256'(dcount), 256'(e.cnt));
        check("uop_in_ready", 256'(ready), 256'(e.rdy));
        check("stall_cycles", 256'(stall), 256'(e.stall));
      end
    end
  end

  initial begin : saturation
    logic [31:0] exp;
    repeat (2) @(posedge clk);
    #1;
    r2 = 1'b0;
    b2 = bnd(4'b0001, IQ_INT, IQ_INT, IQ_INT, IQ_INT);
    @(negedge clk);
    check("sat_ready_after_reset", 256'(ready2), 256'(1));
    check("sat_stall_init", 256'(stall2), 256'(32'hFFFF_FFFC));
    exp = 32'hFFFF_FFFC;
    @(posedge clk);
    #1;
    b2 = '0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("sat_stall", 256'(stall2), 256'(exp));
      check("sat_out_zero", 256'(uop_out2), 256'(0));
      check("sat_ready_low", 256'(ready2), 256'(0));
      exp = (exp == 32'hFFFF_FFFF) ? exp : exp + 32'd1;
    end
    done2 = 1'b1;
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stimulus
    free_t   f4;
    bundle_t z;
    bundle_t rb;
    free_t   rf;
    f4 = fv(4, 4, 4);
    z  = '0;

    step(1, 0, z, f4, 0);
    step(1, 0, z, f4, 1);
    step(0, 0, z, f4, 1);

    step(0, 0, bnd(4'b1111, IQ_INT, IQ_MEM, IQ_INT, IQ_AP), f4, 1);
    step(0, 0, z, f4, 1);
    step(0, 0, z, f4, 1);

    step(0, 0, bnd(4'b1111, IQ_INT, IQ_INT, IQ_MEM, IQ_INT), f4, 1);
    step(0, 0, z, fv(1, 4, 4), 1);
    step(0, 0, bnd(4'b0011, IQ_MEM, IQ_INT, IQ_INT, IQ_INT), f4, 1);

    repeat (5) step(0, 0, z, fv(4, 0, 4), 1);
    step(0, 0, z, fv(4, 1, 4), 1);

    step(0, 0, bnd(4'b1111, IQ_INT, IQ_INT, IQ_INT, IQ_INT), f4, 1);
    step(0, 0, z, fv(2, 4, 4), 1);
    step(0, 1, bnd(4'b1111, IQ_MEM, IQ_MEM, IQ_MEM, IQ_MEM), f4, 1);
    step(0, 0, z, f4, 1);
    step(0, 0, bnd(4'b1111, IQ_INT, IQ_INT, IQ_INT, IQ_INT), fv(7, 7, 7), 1);
    step(0, 0, z, fv(1, 1, 1), 1);
    step(1, 1, z, f4, 1);
    step(0, 0, z, f4, 1);

    step(0, 0, bnd(4'b0101, IQ_AP, IQ_AP, IQ_AP, IQ_AP), f4, 1);
    step(0, 0, z, fv(4, 4, 1), 1);
    step(0, 0, z, fv(4, 4, 1), 1);
    step(0, 0, bnd(4'b1111, IQ_INT, 2'd3, IQ_MEM, 2'd3), f4, 1);
    step(0, 0, z, f4, 1);
    step(0, 0, z, fv(0, 0, 0), 1);

    for (int t = 0; t < 400; t++) begin
      for (int i = 0; i < WIDTH; i++) begin
        rb[i].valid   = ($urandom_range(0, 3) != 0);
        rb[i].iq_code = 2'($urandom_range(0, 3));
        rb[i].payload = 16'($urandom);
      end
      for (int q = 0; q < NUM_IQ; q++) rf[q] = CW'($urandom_range(0, 6));
      step(($urandom_range(0, 59) == 0), ($urandom_range(0, 19) == 0), rb, rf, 1);
    end

    step(0, 0, z, f4, 1);
    step(0, 0, z, f4, 1);
    repeat (3) @(posedge clk);
    for (int k = 0; k < 50 && !done2; k++) @(posedge clk);
    check("scoreboard_drained", 256'(sb.size()), 256'(0));
    check("saturation_block_done", 256'(done2), 256'(1));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
